// File: rtl/wordle_board_if.sv
// wordle_board_if: key/target/read-port bundle between the Wordle board and
// its driver. With WORD_CHECK_EN defined the bundle also carries the
// dictionary answer (in_db) and the refused-enter pulse (reject).
interface wordle_board_if;
    logic        new_game;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [24:0] target;
    logic [2:0]  rd_row;
    logic [2:0]  rd_col;
    logic [6:0]  display;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [24:0] guess_word;
    logic [2:0]  cur_row;
    logic [2:0]  cur_col;
    logic        key_ready;
    logic        busy;
    logic        win;
    logic        lose;
`ifdef WORD_CHECK_EN
    logic        in_db;
    logic        reject;
`endif

    modport master (
`ifdef WORD_CHECK_EN
        output in_db,
        input  reject,
`endif
        output new_game, key_valid, key_code, target, rd_row, rd_col,
        input  display, row, col, guess_word, cur_row, cur_col,
        input  key_ready, busy, win, lose
    );

    modport slave (
`ifdef WORD_CHECK_EN
        input  in_db,
        output reject,
`endif
        input  new_game, key_valid, key_code, target, rd_row, rd_col,
        output display, row, col, guess_word, cur_row, cur_col,
        output key_ready, busy, win, lose
    );
endinterface

// File: rtl/wordle_board.sv
// wordle_board: 6x5 Wordle grid (letter + colour per cell), key-event editor
// and two-pass guess scorer (greens first, then yellows against the unused
// target letters), with a 1-cycle registered read port for the VGA renderer.
// Optional feature macro: WORD_CHECK_EN (dictionary gate on enter).
module wordle_board #(
    parameter int ROWS = 6,
    parameter int COLS = 5
) (
    input  logic           dclk,
    input  logic           clr_n,
    wordle_board_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    // Flat cell index of (row, col); callers keep the address in range.
    function automatic logic [4:0] cell_addr(input logic [2:0] r, input logic [2:0] c);
        return (5'(r) * 5'(COLS)) + 5'(c);
    endfunction

    // Letter i of a packed five-letter word.
    function automatic logic [4:0] letter_at(input logic [24:0] w, input logic [2:0] i);
        logic [4:0] l;
        case (i)
            3'd0:    l = w[4:0];
            3'd1:    l = w[9:5];
            3'd2:    l = w[14:10];
            3'd3:    l = w[19:15];
            3'd4:    l = w[24:20];
            default: l = 5'd0;
        endcase
        return l;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  cur_row_q, cur_row_d;
    logic [2:0]  cur_col_q, cur_col_d;
    logic [6:0]  cell_q [ROWS*COLS];
    logic [6:0]  cell_d [ROWS*COLS];
    logic [1:0]  colour_q [COLS];
    logic [1:0]  colour_d [COLS];
    logic [COLS-1:0] used_q, used_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;
    logic [6:0]  display_q, display_d;
    logic [2:0]  row_q, col_q;
`ifdef WORD_CHECK_EN
    logic        reject_q, reject_d;
`endif

    logic [24:0] guess_s;
    logic        key_ready_s;
    logic        key_go_s;
    logic        word_ok_s;
    logic        all_green_s;
    logic        yel_found_s;
    logic [2:0]  yel_j_s;
    logic [4:0]  cur_letter_s;

    assign key_ready_s = (state_q == S_IDLE) && !win_q && !lose_q;
    assign key_go_s    = bus.key_valid && key_ready_s;
`ifdef WORD_CHECK_EN
    assign word_ok_s   = bus.in_db;
`else
    assign word_ok_s   = 1'b1;
`endif

    // Gather the letters of the row being edited.
    always_comb begin
        guess_s = 25'd0;
        for (int c = 0; c < COLS; c++) begin
            guess_s[c*5 +: 5] = (cur_row_q < 3'(ROWS)) ? cell_q[cell_addr(cur_row_q, 3'(c))][4:0] : 5'd0;
        end
    end

    // Yellow search: lowest unused target position holding the current guess letter.
    always_comb begin
        cur_letter_s = letter_at(guess_s, idx_q);
        yel_found_s  = 1'b0;
        yel_j_s      = 3'd0;
        for (int j = COLS - 1; j >= 0; j--) begin
            yel_found_s = yel_found_s | (!used_q[j] && (letter_at(bus.target, 3'(j)) == cur_letter_s));
            yel_j_s     = (!used_q[j] && (letter_at(bus.target, 3'(j)) == cur_letter_s)) ? 3'(j) : yel_j_s;
        end
    end

    // Row is a win when every column scored green.
    always_comb begin
        all_green_s = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            all_green_s = all_green_s & (colour_q[c] == 2'd1);
        end
    end

    // Next-state logic: board editing, scoring FSM and game-over flags.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        cell_d    = cell_q;
        colour_d  = colour_q;
        used_d    = used_q;
        win_d     = win_q;
        lose_d    = lose_q;
`ifdef WORD_CHECK_EN
        reject_d  = 1'b0;
`endif
        if (bus.new_game) begin
            state_d   = S_IDLE;
            idx_d     = 3'd0;
            cur_row_d = 3'd0;
            cur_col_d = 3'd0;
            used_d    = '0;
            win_d     = 1'b0;
            lose_d    = 1'b0;
            for (int c = 0; c < COLS; c++) colour_d[c] = 2'd0;
            for (int k = 0; k < ROWS*COLS; k++) cell_d[k] = 7'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_go_s && (bus.key_code >= 5'd1) && (bus.key_code <= 5'd26)) begin
                        if (cur_col_q < 3'(COLS)) begin
                            cell_d[cell_addr(cur_row_q, cur_col_q)] = {2'b00, bus.key_code};
                            cur_col_d = cur_col_q + 3'd1;
                        end else begin
                            cur_col_d = cur_col_q;
                        end
                    end else if (key_go_s && (bus.key_code == 5'd30)) begin
                        if (cur_col_q > 3'd0) begin
                            cur_col_d = cur_col_q - 3'd1;
                            cell_d[cell_addr(cur_row_q, cur_col_q - 3'd1)] = 7'd0;
                        end else begin
                            cur_col_d = cur_col_q;
                        end
                    end else if (key_go_s && (bus.key_code == 5'd31) && (cur_col_q == 3'(COLS))) begin
                        if (word_ok_s) begin
                            state_d = S_GREEN;
                            idx_d   = 3'd0;
                            used_d  = '0;
                            for (int c = 0; c < COLS; c++) colour_d[c] = 2'd0;
                        end else begin
                            state_d = S_IDLE;
`ifdef WORD_CHECK_EN
                            reject_d = 1'b1;
`endif
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_GREEN: begin
                    if (cur_letter_s == letter_at(bus.target, idx_q)) begin
                        colour_d[idx_q] = 2'd1;
                        used_d[idx_q]   = 1'b1;
                    end else begin
                        colour_d[idx_q] = 2'd0;
                    end
                    if (idx_q == 3'(COLS - 1)) begin
                        state_d = S_YELLOW;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end
                S_YELLOW: begin
                    if (colour_q[idx_q] == 2'd1) begin
                        colour_d[idx_q] = 2'd1;
                    end else if (yel_found_s) begin
                        colour_d[idx_q] = 2'd2;
                        used_d[yel_j_s] = 1'b1;
                    end else begin
                        colour_d[idx_q] = 2'd0;
                    end
                    if (idx_q == 3'(COLS - 1)) begin
                        state_d = S_COMMIT;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end
                S_COMMIT: begin
                    for (int c = 0; c < COLS; c++) begin
                        cell_d[cell_addr(cur_row_q, 3'(c))][6:5] = colour_q[c];
                    end
                    win_d  = all_green_s;
                    lose_d = !all_green_s && (cur_row_q == 3'(ROWS - 1));
                    if (!all_green_s && (cur_row_q != 3'(ROWS - 1))) begin
                        cur_row_d = cur_row_q + 3'd1;
                        cur_col_d = 3'd0;
                    end else begin
                        cur_row_d = cur_row_q;
                    end
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Read port: in-range addresses return the cell, anything else reads as blank.
    always_comb begin
        if ((bus.rd_row < 3'(ROWS)) && (bus.rd_col < 3'(COLS))) begin
            display_d = cell_q[cell_addr(bus.rd_row, bus.rd_col)];
        end else begin
            display_d = 7'd0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            cur_row_q <= 3'd0;
            cur_col_q <= 3'd0;
            used_q    <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            display_q <= 7'd0;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            for (int c = 0; c < COLS; c++) colour_q[c] <= 2'd0;
            for (int k = 0; k < ROWS*COLS; k++) cell_q[k] <= 7'd0;
`ifdef WORD_CHECK_EN
            reject_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            used_q    <= used_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            display_q <= display_d;
            row_q     <= bus.rd_row;
            col_q     <= bus.rd_col;
            colour_q  <= colour_d;
            cell_q    <= cell_d;
`ifdef WORD_CHECK_EN
            reject_q  <= reject_d;
`endif
        end
    end

    assign bus.display    = display_q;
    assign bus.row        = row_q;
    assign bus.col        = col_q;
    assign bus.guess_word = guess_s;
    assign bus.cur_row    = cur_row_q;
    assign bus.cur_col    = cur_col_q;
    assign bus.key_ready  = key_ready_s;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.win        = win_q;
    assign bus.lose       = lose_q;
`ifdef WORD_CHECK_EN
    assign bus.reject     = reject_q;
`endif

endmodule
